// File: rtl/multiport_register_file.sv
// multiport_register_file: zero-initialised register file with issue scoreboard; REGFILE_BYPASS_EN enables write-first forwarding.
module multiport_register_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 2,
    parameter int DEBUG_REG     = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  ra,
    output logic [NUM_READ*DATA_WIDTH-1:0]     rd,
    output logic [NUM_READ-1:0]               rd_busy,
    input  logic [NUM_WRITE-1:0]              we,
    input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wa,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]    wd,
    input  logic                              iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]          iss_addr,
    output logic                              ready,
    output logic [DATA_WIDTH-1:0]             a0
);
    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam int NP    = NUM_READ + 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_WRITE-1:0]     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr [NUM_WRITE];
    logic [DATA_WIDTH-1:0]    wr_data [NUM_WRITE];
    logic                     set_en;

    assign ready  = state_q == RUN;
    assign set_en = ready && iss_valid && iss_addr != '0;

    for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wp
        assign wr_addr[j] = wa[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign wr_data[j] = wd[j*DATA_WIDTH +: DATA_WIDTH];
        assign wr_en[j]   = ready && we[j] && wr_addr[j] != '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        busy_d  = busy_q;
        if (!ready) begin
            mem_d[cnt_q] = '0;
            cnt_d        = cnt_q + ADDRESS_WIDTH'(1);
            state_d      = &cnt_q ? RUN : CLEAR;
        end else begin
            // Ascending port order lets the higher port win a same-address collision.
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_en[j]) begin
                    mem_d[wr_addr[j]]  = wr_data[j];
                    busy_d[wr_addr[j]] = 1'b0;
                end
            end
            if (set_en) busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // The array is deliberately left untouched on a reset edge; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            mem_q   <= mem_d;
        end
    end

    for (genvar i = 0; i < NP; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
        if (i < NUM_READ) begin : g_ra
            assign addr = ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end else begin : g_dbg
            assign addr = ADDRESS_WIDTH'(DEBUG_REG);
        end
        always_comb begin
            data = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WRITE; j++)
                if (wr_en[j] && wr_addr[j] == addr) data = wr_data[j];
`endif
            if (!ready || addr == '0) data = '0;
        end
        if (i < NUM_READ) begin : g_out
            logic busy;
            always_comb begin
                busy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NUM_WRITE; j++)
                    if (wr_en[j] && wr_addr[j] == addr) busy = set_en && iss_addr == addr;
`endif
                if (!ready) busy = 1'b0;
            end
            assign rd[i*DATA_WIDTH +: DATA_WIDTH] = data;
            assign rd_busy[i]                     = busy;
        end else begin : g_a0
            assign a0 = data;
        end
    end
endmodule

// File: tb/tb_multiport_register_file.sv
// tb_multiport_register_file: randomized and directed checks against a behavioural register-file model.
module tb_multiport_register_file;
    localparam int DW = 32, AW = 5, NR = 2, NW = 2, DBG = 10, DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  wa;
    logic [NW*DW-1:0]  wd;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic              ready;
    logic [DW-1:0]     a0;

    int tests = 0, fails = 0;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy [DEPTH];
    int            m_since = 0;

    always #5 clk = ~clk;

    multiport_register_file #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .DEBUG_REG(DBG)
    ) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_busy(rd_busy), .we(we), .wa(wa), .wd(wd),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .ready(ready), .a0(a0)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_since >= DEPTH;
    endfunction

    function automatic logic [DW-1:0] exp_rd(int a);
        logic [DW-1:0] v;
        if (!m_ready() || a == 0) return '0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NW; j++) if (we[j] && int'(wa[j*AW +: AW]) == a) v = wd[j*DW +: DW];
`endif
        return v;
    endfunction

    function automatic bit exp_busy(int a);
        bit b;
        if (!m_ready() || a == 0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (we[j] && int'(wa[j*AW +: AW]) == a) b = iss_valid && int'(iss_addr) == a;
`endif
        return b;
    endfunction

    task automatic m_edge();
        if (rst) begin
            m_since = 0;
            foreach (m_busy[k]) m_busy[k] = 1'b0;
        end else if (!m_ready()) begin
            m_since++;
            if (m_since == DEPTH) foreach (m_mem[k]) m_mem[k] = '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa[j*AW +: AW] != '0) begin
                    m_mem[wa[j*AW +: AW]]  = wd[j*DW +: DW];
                    m_busy[wa[j*AW +: AW]] = 1'b0;
                end
            end
            if (iss_valid && iss_addr != '0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic cycle(string tag);
        #2;
        check({tag, ".ready"}, ready, m_ready());
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s.rd%0d", tag, i), rd[i*DW +: DW], exp_rd(ra[i*AW +: AW]));
            check($sformatf("%s.busy%0d", tag, i), rd_busy[i], exp_busy(ra[i*AW +: AW]));
        end
        check({tag, ".a0"}, a0, exp_rd(DBG));
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic wr(int p, int a, logic [DW-1:0] d);
        we[p] = 1'b1;
        wa[p*AW +: AW] = AW'(a);
        wd[p*DW +: DW] = d;
    endtask

    task automatic wait_ready(string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            cycle(tag);
            n++;
        end
        check({tag, ".latency"}, n, DEPTH);
    endtask

    task automatic scan(string tag);
        idle();
        for (int a = 0; a < DEPTH; a += 2) begin
            ra = {AW'(a + 1), AW'(a)};
            cycle(tag);
        end
    endtask

    initial begin
        logic [DW-1:0] byp_exp;
        idle();
        ra  = '0;
        rst = 1'b1;
        @(posedge clk);
        m_edge();
        #1;
        rst = 1'b0;
        wait_ready("init");

        for (int a = 0; a < DEPTH; a += 2) begin
            idle();
            wr(0, a, '1);
            wr(1, a + 1, '1);
            iss_valid = 1'b1;
            iss_addr  = AW'(a + 3);
            ra = {AW'(a), AW'(a + 1)};
            cycle("fill");
        end
        idle();
        ra = {AW'(31), AW'(3)};
        cycle("fill_rd");
        rst = 1'b1;
        cycle("rst_run");
        rst = 1'b0;
        wait_ready("reinit");
        scan("post_rst");

        idle();
        wr(0, 5, 32'h11);
        wr(1, 5, 32'h22);
        ra = {AW'(0), AW'(5)};
        cycle("dual");
        idle();
        #1;
        check("dual_wr", rd[DW-1:0], 32'h22);
        wr(0, 0, 32'hDEAD);
        cycle("x0_wr");
        idle();
        #1;
        check("x0_rd", rd[2*DW-1:DW], 32'h0);

        ra = {AW'(0), AW'(7)};
        iss_valid = 1'b1;
        iss_addr  = 7;
        cycle("iss7");
        idle();
        #1;
        check("busy_set", rd_busy[0], 1'b1);
        wr(0, 7, 32'h55);
        cycle("wr7");
        idle();
        #1;
        check("busy_clr", rd_busy[0], 1'b0);
        wr(1, 7, 32'h66);
        iss_valid = 1'b1;
        iss_addr  = 7;
        cycle("set_clr7");
        idle();
        #1;
        check("busy_set_wins", rd_busy[0], 1'b1);
        check("wr7_data", rd[DW-1:0], 32'h66);

        ra = {AW'(0), AW'(10)};
        wr(0, 10, 32'hCAFE);
        #1;
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'hCAFE;
`else
        byp_exp = 32'h0;
`endif
        check("byp_rd0", rd[DW-1:0], byp_exp);
        check("byp_a0", a0, byp_exp);
        cycle("byp");
        idle();
        #1;
        check("byp_next_rd0", rd[DW-1:0], 32'hCAFE);
        check("byp_next_a0", a0, 32'hCAFE);

        for (int a = 1; a < 6; a++) begin
            iss_valid = 1'b1;
            iss_addr  = AW'(a * 5);
            cycle("pre_mid");
        end
        idle();
        rst = 1'b1;
        cycle("rst_a");
        rst = 1'b0;
        for (int k = 0; k < 12; k++) cycle("mid_clr");
        check("mid_ready", ready, 1'b0);
        rst = 1'b1;
        cycle("rst_b");
        rst = 1'b0;
        wait_ready("mid");
        scan("mid_scan");

        for (int c = 0; c < 1500; c++) begin
            rst = $urandom_range(0, 299) == 0;
            we  = NW'($urandom);
            for (int j = 0; j < NW; j++) begin
                wa[j*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                wd[j*DW +: DW] = $urandom;
            end
            iss_valid = 1'($urandom);
            iss_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            for (int i = 0; i < NR; i++)
                ra[i*AW +: AW] = $urandom_range(0, 3) == 0 ? AW'(DBG) : AW'($urandom_range(0, 9));
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register and data width.
REQ-002 Parameter ADDRESS_WIDTH, default 5: register address width; the depth is 2**ADDRESS_WIDTH.
REQ-003 Parameter NUM_READ, default 2: number of read ports, range 1..4.
REQ-004 Parameter NUM_WRITE, default 2: number of write ports, range 1..2.
REQ-005 Parameter DEBUG_REG, default 10: index of the register mirrored on a0.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 ra  in  NUM_READ*ADDRESS_WIDTH  read addresses; port i occupies slice i.
REQ-009 rd  out  NUM_READ*DATA_WIDTH  read data, combinational from ra.
REQ-010 rd_busy  out  NUM_READ  pending-write flag of each read address.
REQ-011 we  in  NUM_WRITE  per-port write enable.
REQ-012 wa  in  NUM_WRITE*ADDRESS_WIDTH  write addresses.
REQ-013 wd  in  NUM_WRITE*DATA_WIDTH  write data.
REQ-014 iss_valid  in  1  an instruction is issued that will write iss_addr.
REQ-015 iss_addr  in  ADDRESS_WIDTH  destination register of the issued instruction.
REQ-016 ready  out  1  high when the register file is initialised and accepting writes.
REQ-017 a0  out  DATA_WIDTH  current value of register DEBUG_REG.

Function
REQ-018 The block SHALL implement a two-state FSM: CLEAR (zeroing the array) and RUN (normal operation).
REQ-019 In CLEAR, each cycle SHALL write zero to reg[cnt] and increment cnt; after writing index 2**ADDRESS_WIDTH-1, the FSM SHALL move to RUN.
REQ-020 ready SHALL equal (state==RUN); in CLEAR, inputs we and iss_valid SHALL be ignored, and rd, rd_busy and a0 SHALL read 0.
REQ-021 In RUN, on a clock edge with we[j]=1 and wa[j]!=0, reg[wa[j]] SHALL be set to wd[j]; writes to address 0 SHALL be discarded, and reg[0] SHALL always read 0.
REQ-022 When both write ports target the same nonzero address in one cycle, port 1 SHALL win.
REQ-023 Scoreboard: in RUN, iss_valid=1 with iss_addr!=0 SHALL set busy[iss_addr] on the next edge.
REQ-024 In RUN, a write on any port SHALL clear busy[wa[j]] on the same edge.
REQ-025 When a set and a clear of the same address occur in one cycle, the set SHALL win and busy SHALL remain 1.
REQ-026 busy[0] SHALL always be 0.
REQ-027 rd_busy[i] SHALL equal busy[ra[i]], subject to REQ-032.
REQ-028 Read latency SHALL be 0 cycles (combinational); write latency SHALL be 1 edge.

Reset
REQ-029 While rst=1 at an edge, the block SHALL set state=CLEAR and cnt=0, and clear all busy bits in that same edge; the array contents SHALL NOT be modified on that edge.
REQ-030 Asserting rst mid-CLEAR or mid-RUN SHALL restart the clear sequence from index 0.
REQ-031 ready SHALL first be high exactly 2**ADDRESS_WIDTH edges after the first edge with rst=0; the default configuration gives 32 edges.

Configuration
REQ-032 With macro REGFILE_BYPASS_EN defined, write-first forwarding SHALL apply in RUN:
- If ra[i] matches a nonzero wa[j] with we[j]=1 in the same cycle, rd[i] SHALL return wd[j], with port priority as in REQ-022.
- In that same case, rd_busy[i] SHALL be 0, unless a set of that address also occurs in the cycle.
- a0 SHALL forward the same way.
REQ-033 Without REGFILE_BYPASS_EN, rd, rd_busy and a0 SHALL reflect only registered state; a same-cycle write SHALL become visible on the next cycle.

Verification
REQ-034 Initialisation: pulse rst 1 cycle after filling registers with 0xFFFFFFFF -> ready=0 for 32 cycles; afterwards every ra returns 0x00000000.
REQ-035 Dual-write conflict: we=2'b11, wa0=wa1=5, wd0=0x11, wd1=0x22 -> next cycle rd at ra=5 returns 0x22; a write to x0 with 0xDEAD -> reads 0.
REQ-036 Scoreboard: iss_valid with iss_addr=7 -> rd_busy=1 at ra=7 next cycle; a write to 7 clears it; a simultaneous iss_addr=7 and we to 7 -> busy stays 1.
REQ-037 Bypass: with the macro defined, write 0xCAFE to x10 while ra0=10 -> rd0=0xCAFE and a0=0xCAFE in the same cycle; without the macro, rd0 holds the old value until the next cycle.
REQ-038 Reset mid-operation: assert rst at clear count 12 -> count restarts at 0; ready rises 32 edges after rst falls; all busy bits are 0.
